ps2_kbd_seq: RTL and testbench

- Sequences the PS/2 keyboard FIFO read handshake (ready / nextdata_n) and decodes the raw scan-code stream into key events.
- Decoding covers make, break (F0) and extended (E0) codes.
- Tracks the currently held key, suppresses typematic repeats and counts distinct key presses.
- Sits between the PS/2 receiver FIFO and the display/ASCII logic. It is the sole consumer of the FIFO.

---
 rtl/ps2_kbd_seq_if.sv | 22 ++
 rtl/ps2_kbd_seq.sv | 100 ++++++++++
 tb/tb_ps2_kbd_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_seq_if.sv
// Read-side handshake between the PS/2 receiver FIFO (master) and its
// single consumer, the keyboard sequencer (slave).
interface ps2_kbd_seq_if;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata_n;

  modport master (
    output fifo_data,
    output fifo_ready,
    output fifo_overflow,
    input  fifo_nextdata_n
  );

  modport slave (
    input  fifo_data,
    input  fifo_ready,
    input  fifo_overflow,
    output fifo_nextdata_n
  );
endinterface

// File: rtl/ps2_kbd_seq.sv
// Pops scan codes from the PS/2 receiver FIFO, strips E0/F0 prefixes and
// turns the stream into press/release events with held-key tracking.
module ps2_kbd_seq #(
  parameter int CNT_W           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_kbd_seq_if.slave     fifo,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_code,
  output logic             err_ovf
);

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t state;
  logic   ext_flag;
  logic   brk_flag;
  logic   is_match;
  logic   emit;

  // A byte "matches" when it names the key that is currently held down.
  assign is_match = key_held && (held_code == fifo.fifo_data) && (held_ext == ext_flag);
  assign emit     = brk_flag || !is_match || !SUPPRESS_REPEAT;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state                <= IDLE;
      fifo.fifo_nextdata_n <= 1'b1;
      ext_flag             <= 1'b0;
      brk_flag             <= 1'b0;
      key_valid            <= 1'b0;
      key_code             <= 8'h00;
      key_ext              <= 1'b0;
      key_release          <= 1'b0;
      key_repeat           <= 1'b0;
      key_held             <= 1'b0;
      held_code            <= 8'h00;
      held_ext             <= 1'b0;
      press_cnt            <= '0;
      err_code             <= 1'b0;
      err_ovf              <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (fifo.fifo_overflow) err_ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (fifo.fifo_ready) begin
            fifo.fifo_nextdata_n <= 1'b0;
            state                <= POP;
            case (fifo.fifo_data)
              8'hE0: ext_flag <= 1'b1;
              8'hF0: brk_flag <= 1'b1;
              8'h00, 8'hFF: begin
                err_code <= 1'b1;
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
              default: begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                if (emit) begin
                  key_valid   <= 1'b1;
                  key_code    <= fifo.fifo_data;
                  key_ext     <= ext_flag;
                  key_release <= brk_flag;
                  key_repeat  <= !brk_flag && is_match;
                end
                // Only a make of a different (or no) held key counts as a new press.
                if (!brk_flag && !is_match) begin
                  key_held  <= 1'b1;
                  held_code <= fifo.fifo_data;
                  held_ext  <= ext_flag;
                  press_cnt <= press_cnt + CNT_W'(1);
                end
                if (brk_flag && is_match) key_held <= 1'b0;
              end
            endcase
          end
        end
        POP: begin
          fifo.fifo_nextdata_n <= 1'b1;
          state                <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_seq.sv
// Drives two sequencers (repeat suppression on and off) from identical FIFO
// streams and compares their event stream against a behavioural keyboard model.
module tb_ps2_kbd_seq;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic       held;
    logic [7:0] hcode;
    logic       hext;
    logic [7:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic clrn;

  ps2_kbd_seq_if if_s ();
  ps2_kbd_seq_if if_r ();

  logic       s_valid, s_ext, s_rel, s_rep, s_held, s_hext, s_errc, s_erro;
  logic [7:0] s_code, s_hcode, s_cnt;
  logic       r_valid, r_ext, r_rel, r_rep, r_held, r_hext, r_errc, r_erro;
  logic [7:0] r_code, r_hcode, r_cnt;

  ps2_kbd_seq #(.CNT_W(8), .SUPPRESS_REPEAT(1'b1)) dut_s (
    .clk(clk), .clrn(clrn), .fifo(if_s),
    .key_valid(s_valid), .key_code(s_code), .key_ext(s_ext), .key_release(s_rel),
    .key_repeat(s_rep), .key_held(s_held), .held_code(s_hcode), .held_ext(s_hext),
    .press_cnt(s_cnt), .err_code(s_errc), .err_ovf(s_erro)
  );

  ps2_kbd_seq #(.CNT_W(8), .SUPPRESS_REPEAT(1'b0)) dut_r (
    .clk(clk), .clrn(clrn), .fifo(if_r),
    .key_valid(r_valid), .key_code(r_code), .key_ext(r_ext), .key_release(r_rel),
    .key_repeat(r_rep), .key_held(r_held), .held_code(r_hcode), .held_ext(r_hext),
    .press_cnt(r_cnt), .err_code(r_errc), .err_ovf(r_erro)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_r[$];
  ev_t        exp_s[$];
  ev_t        exp_r[$];
  int         pushed;
  int         pops_s, pops_r;
  int         ev_cnt_s, ev_cnt_r;
  logic       last_pop_s, last_pop_r;

  // Keyboard model state, index 0 = suppressing DUT, 1 = repeating DUT
  logic       m_ext[2], m_brk[2], m_held[2], m_hext[2], m_errc[2];
  logic [7:0] m_hcode[2], m_cnt[2];

  logic [7:0] codes[6] = '{8'h1C, 8'h32, 8'h75, 8'h2B, 8'h5A, 8'h29};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelStep(input int d, input logic [7:0] b);
    ev_t  e;
    logic match, fire, rep;
    if (b == 8'hE0) m_ext[d] = 1'b1;
    else if (b == 8'hF0) m_brk[d] = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_errc[d] = 1'b1;
      m_ext[d]  = 1'b0;
      m_brk[d]  = 1'b0;
    end else begin
      match = m_held[d] && m_hcode[d] == b && m_hext[d] == m_ext[d];
      fire  = 1'b1;
      rep   = 1'b0;
      if (m_brk[d]) begin
        if (match) m_held[d] = 1'b0;
      end else if (!match) begin
        m_held[d]  = 1'b1;
        m_hcode[d] = b;
        m_hext[d]  = m_ext[d];
        m_cnt[d]   = m_cnt[d] + 8'd1;
      end else if (d == 0) fire = 1'b0;
      else rep = 1'b1;
      if (fire) begin
        e = '{code: b, ext: m_ext[d], rel: m_brk[d], rep: rep, held: m_held[d],
              hcode: m_hcode[d], hext: m_hext[d], cnt: m_cnt[d]};
        if (d == 0) exp_s.push_back(e);
        else exp_r.push_back(e);
      end
      m_ext[d] = 1'b0;
      m_brk[d] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int max_gap);
    q_s.push_back(b);
    q_r.push_back(b);
    pushed++;
    modelStep(0, b);
    modelStep(1, b);
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic doReset();
    clrn = 1'b0;
    q_s.delete(); q_r.delete(); exp_s.delete(); exp_r.delete();
    pushed = 0; pops_s = 0; pops_r = 0; ev_cnt_s = 0; ev_cnt_r = 0;
    for (int d = 0; d < 2; d++) begin
      m_ext[d] = 0; m_brk[d] = 0; m_held[d] = 0; m_hext[d] = 0; m_errc[d] = 0;
      m_hcode[d] = 8'h00; m_cnt[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_nextdata_s"}, if_s.fifo_nextdata_n, 1);
    checkOutput({tag, "_nextdata_r"}, if_r.fifo_nextdata_n, 1);
    checkOutput({tag, "_outs_s"}, {s_valid, s_code, s_ext, s_rel, s_rep, s_held, s_hcode, s_hext, s_cnt, s_errc, s_erro}, 0);
    checkOutput({tag, "_outs_r"}, {r_valid, r_code, r_ext, r_rel, r_rep, r_held, r_hcode, r_hext, r_cnt, r_errc, r_erro}, 0);
  endtask

  task automatic drainAndCheck(input string tag);
    int n = 0;
    while ((q_s.size() != 0 || q_r.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drain_timeout"}, n >= 5000, 0);
    repeat (4) @(negedge clk);
    checkOutput({tag, "_missing_ev_s"}, exp_s.size(), 0);
    checkOutput({tag, "_missing_ev_r"}, exp_r.size(), 0);
    checkOutput({tag, "_pops_s"}, pops_s, pushed);
    checkOutput({tag, "_pops_r"}, pops_r, pushed);
    checkOutput({tag, "_state_s"}, {s_held, s_hcode, s_hext, s_cnt, s_errc}, {m_held[0], m_hcode[0], m_hext[0], m_cnt[0], m_errc[0]});
    checkOutput({tag, "_state_r"}, {r_held, r_hcode, r_hext, r_cnt, r_errc}, {m_held[1], m_hcode[1], m_hext[1], m_cnt[1], m_errc[1]});
  endtask

  task automatic checkEvent(input int d, input ev_t got);
    ev_t   e;
    string p = (d == 0) ? "ev_s" : "ev_r";
    if ((d == 0 && exp_s.size() == 0) || (d == 1 && exp_r.size() == 0)) begin
      checkOutput({p, "_unexpected"}, {got.code, got.rel, got.rep}, 0);
    end else begin
      e = (d == 0) ? exp_s.pop_front() : exp_r.pop_front();
      checkOutput({p, "_code"}, got.code, e.code);
      checkOutput({p, "_flags"}, {got.ext, got.rel, got.rep}, {e.ext, e.rel, e.rep});
      checkOutput({p, "_held"}, {got.held, got.hcode, got.hext}, {e.held, e.hcode, e.hext});
      checkOutput({p, "_cnt"}, got.cnt, e.cnt);
    end
  endtask

  // FIFO model: head shown mid-cycle, popped on the edge that ends a low strobe
  always @(negedge clk) begin
    if_s.fifo_ready = q_s.size() != 0;
    if_s.fifo_data  = (q_s.size() != 0) ? q_s[0] : 8'h00;
    if_r.fifo_ready = q_r.size() != 0;
    if_r.fifo_data  = (q_r.size() != 0) ? q_r[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (clrn === 1'b1) begin
      if (if_s.fifo_nextdata_n === 1'b0) begin
        checkOutput("pop_empty_s", q_s.size() == 0, 0);
        checkOutput("double_pop_s", last_pop_s, 0);
        if (q_s.size() != 0) void'(q_s.pop_front());
        pops_s++;
      end
      if (if_r.fifo_nextdata_n === 1'b0) begin
        checkOutput("pop_empty_r", q_r.size() == 0, 0);
        checkOutput("double_pop_r", last_pop_r, 0);
        if (q_r.size() != 0) void'(q_r.pop_front());
        pops_r++;
      end
    end
    last_pop_s = (if_s.fifo_nextdata_n === 1'b0);
    last_pop_r = (if_r.fifo_nextdata_n === 1'b0);
  end

  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      if (s_valid === 1'b1) begin
        ev_cnt_s++;
        checkEvent(0, '{code: s_code, ext: s_ext, rel: s_rel, rep: s_rep, held: s_held,
                        hcode: s_hcode, hext: s_hext, cnt: s_cnt});
      end
      if (r_valid === 1'b1) begin
        ev_cnt_r++;
        checkEvent(1, '{code: r_code, ext: r_ext, rel: r_rel, rep: r_rep, held: r_held,
                        hcode: r_hcode, hext: r_hext, cnt: r_cnt});
      end
    end
  end

  initial begin
    int         n;
    int         r;
    logic [7:0] c;
    clrn = 1'b0;
    last_pop_s = 1'b0;
    last_pop_r = 1'b0;
    if_s.fifo_overflow = 1'b0;
    if_r.fifo_overflow = 1'b0;
    doReset();

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) begin
      checkIdleOutputs("idle");
      @(negedge clk);
    end
    checkOutput("idle_pops", pops_s + pops_r, 0);

    $display("[TB] make/break 1C");
    applyStimulus(8'h1C, 3);
    applyStimulus(8'hF0, 3);
    applyStimulus(8'h1C, 3);
    drainAndCheck("mkbrk");
    checkOutput("mkbrk_cnt", s_cnt, 1);
    checkOutput("mkbrk_events", ev_cnt_s, 2);

    $display("[TB] extended key 75");
    doReset();
    foreach (codes[i]) if (i < 2) applyStimulus(i == 0 ? 8'hE0 : 8'h75, 0);
    drainAndCheck("ext_press");
    checkOutput("ext_held", {s_held, s_hext, s_hcode}, {1'b1, 1'b1, 8'h75});
    applyStimulus(8'hE0, 6);
    applyStimulus(8'hF0, 6);
    applyStimulus(8'h75, 0);
    drainAndCheck("ext_rel");
    checkOutput("ext_cnt", {s_cnt, s_held}, {8'd1, 1'b0});

    $display("[TB] typematic");
    doReset();
    repeat (4) applyStimulus(8'h1C, 1);
    drainAndCheck("typ");
    checkOutput("typ_events_s", ev_cnt_s, 1);
    checkOutput("typ_events_r", ev_cnt_r, 4);
    checkOutput("typ_cnt_r", r_cnt, 1);

    $display("[TB] error codes and overflow");
    doReset();
    applyStimulus(8'hE0, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h32, 0);
    drainAndCheck("err");
    checkOutput("err_code", {s_errc, r_errc}, 2'b11);
    if_s.fifo_overflow = 1'b1;
    if_r.fifo_overflow = 1'b1;
    @(negedge clk);
    if_s.fifo_overflow = 1'b0;
    if_r.fifo_overflow = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("err_ovf_sticky", {s_erro, r_erro}, 2'b11);

    $display("[TB] reset during pop");
    doReset();
    checkIdleOutputs("post_reset");
    applyStimulus(8'h2B, 0);
    n = 0;
    while (if_s.fifo_nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pop_wait_timeout", n >= 50, 0);
    #1 clrn = 1'b0;
    #1 checkIdleOutputs("midpop");
    doReset();
    applyStimulus(8'h2B, 0);
    drainAndCheck("fresh");
    checkOutput("fresh_cnt", s_cnt, 1);

    $display("[TB] press counter wrap");
    doReset();
    for (int i = 0; i < 256; i++) begin
      c = codes[$urandom_range(0, 5)];
      applyStimulus(c, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(c, 0);
    end
    drainAndCheck("wrap");
    checkOutput("wrap_cnt", {s_cnt, r_cnt}, 16'h0000);

    $display("[TB] random stream");
    doReset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r < 2) c = 8'hE0;
      else if (r < 4) c = 8'hF0;
      else if (r == 4 && $urandom_range(0, 3) == 0) c = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else c = codes[$urandom_range(0, 3)];
      applyStimulus(c, 4);
    end
    drainAndCheck("rand");

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
